// File: rtl/rot_count_seq_pkg.sv
// Shared encodings for the multi-cycle rotate count sequencer.
// Function codes, FSM states and per-pass chunk limits.
package rot_count_seq_pkg;

    localparam logic [1:0] FN_ROR = 2'b00;
    localparam logic [1:0] FN_ROL = 2'b01;
    localparam logic [1:0] FN_RCR = 2'b10;
    localparam logic [1:0] FN_RCL = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] CHUNK_WORD = 8'd16;
    localparam logic [7:0] CHUNK_BYTE = 8'd8;

endpackage

// File: rtl/rot_count_seq_if.sv
// Request/result bundle between the issue stage and the sequencer.
// The master drives requests; the slave returns status and results.
interface rot_count_seq_if;

    logic        start;
    logic [15:0] x;
    logic [7:0]  count;
    logic [1:0]  func;
    logic        word_op;
    logic        cfi;
    logic        ofi;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        cfo;
    logic        ofo;

    modport master (
        output start, x, count, func, word_op, cfi, ofi,
        input  busy, done, out, cfo, ofo
    );

    modport slave (
        input  start, x, count, func, word_op, cfi, ofi,
        output busy, done, out, cfo, ofo
    );

endinterface

// File: rtl/rot_count_seq_rotate.sv
// Single-pass rotate datapath; correct for y up to the operand width.
// Byte ops rotate x[7:0] and pass x[15:8] through unchanged.
module rotate
    import rot_count_seq_pkg::*;
(
    input  logic [15:0] x,
    input  logic [4:0]  y,
    input  logic [1:0]  func,
    input  logic        cfi,
    input  logic        ofi,
    input  logic        word_op,
    output logic [15:0] out,
    output logic        cfo,
    output logic        ofo
);

    logic [16:0] rc_w;
    logic [8:0]  rc_b;
    logic [15:0] res;
    logic        c;
    logic        msb;
    logic        nmsb;

    always_comb begin
        rc_w = '0;
        rc_b = '0;
        res  = x;
        c    = cfi;
        // Rotations are formed by right-shifting a doubled operand.
        unique case (func)
            FN_ROL: begin
                if (word_op) res = 16'({x, x} >> (5'd16 - y));
                else res = {x[15:8], 8'({x[7:0], x[7:0]} >> (5'd8 - y))};
                c = res[0];
            end
            FN_ROR: begin
                if (word_op) res = 16'({x, x} >> y);
                else res = {x[15:8], 8'({x[7:0], x[7:0]} >> y)};
                c = word_op ? res[15] : res[7];
            end
            FN_RCL: begin
                rc_w = 17'({cfi, x, cfi, x} >> (5'd17 - y));
                rc_b = 9'({cfi, x[7:0], cfi, x[7:0]} >> (5'd9 - y));
                res  = word_op ? rc_w[15:0] : {x[15:8], rc_b[7:0]};
                c    = word_op ? rc_w[16] : rc_b[8];
            end
            FN_RCR: begin
                rc_w = 17'({cfi, x, cfi, x} >> y);
                rc_b = 9'({cfi, x[7:0], cfi, x[7:0]} >> y);
                res  = word_op ? rc_w[15:0] : {x[15:8], rc_b[7:0]};
                c    = word_op ? rc_w[16] : rc_b[8];
            end
        endcase
        msb  = word_op ? res[15] : res[7];
        nmsb = word_op ? res[14] : res[6];
        if (y == 5'd0) begin
            out = x;
            cfo = cfi;
            ofo = ofi;
        end else begin
            out = res;
            cfo = c;
            ofo = func[0] ? (msb ^ c) : (msb ^ nmsb);
        end
    end

endmodule

// File: rtl/rot_count_seq.sv
// Count sequencer: splits an unmasked 8-bit rotate count into
// single-pass chunks for the rotate datapath, feeding CF/OF back.
module rot_count_seq
    import rot_count_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    rot_count_seq_if.slave bus
);

    logic [1:0]  state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic        cf_q, cf_d;
    logic        of_q, of_d;
    logic [7:0]  rem_q, rem_d;
    logic [1:0]  func_q, func_d;
    logic        word_q, word_d;
    logic [15:0] out_q, out_d;
    logic        cfo_q, cfo_d;
    logic        ofo_q, ofo_d;

    logic [7:0]  chunk;
    logic [7:0]  step;
    logic [7:0]  rem_left;
    logic [15:0] rot_out;
    logic        rot_cf;
    logic        rot_of;

    rotate u_rotate (
        .x       (acc_q),
        .y       (5'(step)),
        .func    (func_q),
        .cfi     (cf_q),
        .ofi     (of_q),
        .word_op (word_q),
        .out     (rot_out),
        .cfo     (rot_cf),
        .ofo     (rot_of)
    );

    always_comb begin
        chunk    = word_q ? CHUNK_WORD : CHUNK_BYTE;
        step     = (rem_q < chunk) ? rem_q : chunk;
        rem_left = rem_q - step;
        state_d  = state_q;
        acc_d    = acc_q;
        cf_d     = cf_q;
        of_d     = of_q;
        rem_d    = rem_q;
        func_d   = func_q;
        word_d   = word_q;
        out_d    = out_q;
        cfo_d    = cfo_q;
        ofo_d    = ofo_q;
        unique case (state_q)
            ST_RUN: begin
                acc_d = rot_out;
                cf_d  = rot_cf;
                of_d  = rot_of;
                rem_d = rem_left;
                if (rem_left == 8'd0) begin
                    state_d = ST_DONE;
                    out_d   = rot_out;
                    cfo_d   = rot_cf;
                    ofo_d   = rot_of;
                end
            end
            default: begin
                // DONE accepts a new start just like IDLE.
                state_d = ST_IDLE;
                if (bus.start) begin
                    acc_d  = bus.x;
                    cf_d   = bus.cfi;
                    of_d   = bus.ofi;
                    rem_d  = bus.count;
                    func_d = bus.func;
                    word_d = bus.word_op;
                    if (bus.count == 8'd0) begin
                        state_d = ST_DONE;
                        out_d   = bus.x;
                        cfo_d   = bus.cfi;
                        ofo_d   = bus.ofi;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            rem_q   <= '0;
            func_q  <= FN_ROR;
            word_q  <= 1'b0;
            out_q   <= '0;
            cfo_q   <= 1'b0;
            ofo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            rem_q   <= rem_d;
            func_q  <= func_d;
            word_q  <= word_d;
            out_q   <= out_d;
            cfo_q   <= cfo_d;
            ofo_q   <= ofo_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.out  = out_q;
    assign bus.cfo  = cfo_q;
    assign bus.ofo  = ofo_q;

endmodule

// File: tb/tb_rot_count_seq.sv
// Bench for rot_count_seq: directed cases plus random ops against
// a bit-at-a-time rotate model.
module tb_rot_count_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rot_count_seq_if bus ();

    rot_count_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void model(
        input  logic [15:0] x,
        input  logic [7:0]  cnt,
        input  logic [1:0]  f,
        input  logic        w,
        input  logic        ci,
        input  logic        oi,
        output logic [15:0] ro,
        output logic        rc,
        output logic        rof,
        output int          lat
    );
        int          n;
        logic [15:0] a;
        logic [15:0] mask;
        logic        c;
        logic        b;
        n    = w ? 16 : 8;
        mask = w ? 16'hFFFF : 16'h00FF;
        a    = x & mask;
        c    = ci;
        for (int i = 0; i < int'(cnt); i++) begin
            case (f)
                2'b01: begin b = a[n-1]; a = ((a << 1) | 16'(b)) & mask; c = b; end
                2'b00: begin b = a[0]; a = (a >> 1) | (16'(b) << (n-1)); c = b; end
                2'b11: begin b = a[n-1]; a = ((a << 1) | 16'(c)) & mask; c = b; end
                default: begin b = a[0]; a = (a >> 1) | (16'(c) << (n-1)); c = b; end
            endcase
        end
        ro = w ? a : {x[15:8], a[7:0]};
        rc = c;
        if (cnt == 8'd0) rof = oi;
        else if (f[0]) rof = a[n-1] ^ c;
        else rof = a[n-1] ^ a[n-2];
        lat = (cnt == 8'd0) ? 1 : (int'(cnt) + n - 1) / n + 1;
    endfunction

    task automatic scramble();
        bus.x       = 16'($urandom);
        bus.count   = 8'($urandom);
        bus.func    = 2'($urandom);
        bus.word_op = 1'($urandom);
        bus.cfi     = 1'($urandom);
        bus.ofi     = 1'($urandom);
    endtask

    task automatic issue(
        input logic [15:0] x, input logic [7:0] cnt, input logic [1:0] f,
        input logic w, input logic ci, input logic oi
    );
        bus.start   = 1'b1;
        bus.x       = x;
        bus.count   = cnt;
        bus.func    = f;
        bus.word_op = w;
        bus.cfi     = ci;
        bus.ofi     = oi;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble();
    endtask

    // Issues one op and waits for done; spurious starts while running.
    task automatic exec(
        input  logic [15:0] x, input logic [7:0] cnt, input logic [1:0] f,
        input  logic w, input logic ci, input logic oi, input int junk,
        output int lat, output logic [15:0] o, output logic c,
        output logic ov, output logic bsy
    );
        bit got = 0;
        issue(x, cnt, f, w, ci, oi);
        lat = 0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            if (bus.done) begin
                got = 1;
                bus.start = 1'b0;
            end else if (lat < junk) begin
                bus.start = 1'b1;
                scramble();
            end else begin
                bus.start = 1'b0;
            end
        end
        if (!got) lat = 999;
        o   = bus.out;
        c   = bus.cfo;
        ov  = bus.ofo;
        bsy = bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        scramble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++;
        if (bus.out !== 16'h0) begin errors++; $display("FAIL reset_out got %h exp 0000", bus.out); end
        checks++;
        if ({bus.cfo, bus.ofo} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got %b%b exp 00", bus.cfo, bus.ofo);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] xs [4] = '{16'h8001, 16'h5581, 16'h1234, 16'hBEEF};
        logic [7:0]  cs [4] = '{8'd1, 8'd9, 8'd17, 8'd0};
        logic [1:0]  fs [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
        logic        ws [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        ci [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        oi [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] eo [4] = '{16'h0003, 16'h55C0, 16'h1234, 16'hBEEF};
        logic        ec [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        ev [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          el [4] = '{2, 3, 3, 1};
        int lat;
        logic [15:0] o;
        logic c, ov, bsy;
        for (int i = 0; i < 4; i++) begin
            exec(xs[i], cs[i], fs[i], ws[i], ci[i], oi[i], el[i], lat, o, c, ov, bsy);
            checks++;
            if (lat != el[i]) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, el[i]); end
            checks++;
            if (o !== eo[i]) begin errors++; $display("FAIL dir%0d_out got %h exp %h", i, o, eo[i]); end
            checks++;
            if (c !== ec[i]) begin errors++; $display("FAIL dir%0d_cfo got %b exp %b", i, c, ec[i]); end
            checks++;
            if (ov !== ev[i]) begin errors++; $display("FAIL dir%0d_ofo got %b exp %b", i, ov, ev[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] o;
        logic c, ov, bsy;
        exec(16'h0001, 8'd255, 2'b10, 1'b0, 1'b0, 1'b0, 33, lat, o, c, ov, bsy);
        checks++;
        if (lat != 33) begin errors++; $display("FAIL b2b_long_latency got %0d exp 33", lat); end
        checks++;
        if ({o, c, ov} !== {16'h0040, 1'b0, 1'b1}) begin
            errors++; $display("FAIL b2b_long_result got %h/%b/%b exp 0040/0/1", o, c, ov);
        end
        checks++;
        if (bsy !== 1'b0) begin errors++; $display("FAIL b2b_busy_in_done got %b exp 0", bsy); end
        exec(16'h8001, 8'd1, 2'b01, 1'b1, 1'b0, 1'b0, 0, lat, o, c, ov, bsy);
        checks++;
        if (lat != 2) begin errors++; $display("FAIL b2b_second_latency got %0d exp 2", lat); end
        checks++;
        if ({o, c, ov} !== {16'h0003, 1'b1, 1'b1}) begin
            errors++; $display("FAIL b2b_second_result got %h/%b/%b exp 0003/1/1", o, c, ov);
        end
    endtask

    task automatic test_abort();
        int lat, el;
        logic [15:0] o, eo;
        logic c, ov, bsy, ec, ev;
        issue(16'h0001, 8'd255, 2'b10, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_run got %b exp 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++; $display("FAIL abort_status got %b%b exp 00", bus.busy, bus.done);
        end
        checks++;
        if ({bus.out, bus.cfo, bus.ofo} !== 18'h0) begin
            errors++; $display("FAIL abort_outputs got %h/%b/%b exp 0000/0/0", bus.out, bus.cfo, bus.ofo);
        end
        rst = 1'b0;
        model(16'hA5C3, 8'd20, 2'b11, 1'b1, 1'b1, 1'b0, eo, ec, ev, el);
        exec(16'hA5C3, 8'd20, 2'b11, 1'b1, 1'b1, 1'b0, el, lat, o, c, ov, bsy);
        checks++;
        if (lat != el) begin errors++; $display("FAIL abort_after_latency got %0d exp %0d", lat, el); end
        checks++;
        if ({o, c, ov} !== {eo, ec, ev}) begin
            errors++; $display("FAIL abort_after_result got %h/%b/%b exp %h/%b/%b", o, c, ov, eo, ec, ev);
        end
    endtask

    task automatic test_random();
        int lat, el;
        logic [15:0] x, o, eo;
        logic [7:0] cnt;
        logic [1:0] f;
        logic w, ci, oi, c, ov, bsy, ec, ev;
        for (int i = 0; i < 60; i++) begin
            x   = 16'($urandom);
            cnt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            f   = 2'($urandom);
            w   = 1'($urandom);
            ci  = 1'($urandom);
            oi  = 1'($urandom);
            model(x, cnt, f, w, ci, oi, eo, ec, ev, el);
            exec(x, cnt, f, w, ci, oi, el, lat, o, c, ov, bsy);
            checks++;
            if (lat != el) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, el); end
            checks++;
            if (o !== eo) begin errors++; $display("FAIL rnd%0d_out got %h exp %h", i, o, eo); end
            checks++;
            if ({c, ov} !== {ec, ev}) begin
                errors++; $display("FAIL rnd%0d_flags got %b%b exp %b%b", i, c, ov, ec, ev);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        scramble();
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
